// File: rtl/car_collision_manager.sv
// car_collision_manager
//   Compares the player and AI car boxes once per video frame and runs the
//   crash / grace / game-over sequence.
//   Optional build macro: COLLISION_SPEED_SCALED_CRASH_EN. When defined, the
//   crash stop time is extended by player_speed/64 frames, with the speed
//   sampled on the hit frame.
// Ports:
//   clk, resetN      clock, asynchronous active-low reset
//   frame_start      one-clk pulse per video frame
//   player_state     {img_id, x, y, width, height}, 11-bit unsigned each
//   ai_state         same format, from the AI car controller
//   player_speed     current player speed (optional feature only)
//   collision_pulse  one-clk pulse per accepted hit
//   crashed          high while stopped after a hit
//   invulnerable     high during the post-crash grace period
//   lives            remaining lives
//   game_over        sticky, high once lives reach 0
//   speed_limit      ceiling applied to player speed
module car_collision_manager #(
    parameter int         NUM_LIVES    = 3,
    parameter int         CRASH_FRAMES = 60,
    parameter int         GRACE_FRAMES = 90,
    parameter int         MARGIN       = 4,
    parameter logic [9:0] SPEED_MAX    = 10'd1023
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             frame_start,
    input  logic [0:4][0:10] player_state,
    input  logic [0:4][0:10] ai_state,
    input  logic [0:9]       player_speed,
    output logic             collision_pulse,
    output logic             crashed,
    output logic             invulnerable,
    output logic [2:0]       lives,
    output logic             game_over,
    output logic [9:0]       speed_limit
);

    typedef enum logic [1:0] {
        DRIVE = 2'd0,
        CRASH = 2'd1,
        GRACE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [11:0] MARGIN_W = 12'(MARGIN);
    localparam logic [11:0] MIN_SIZE = 12'(2 * MARGIN);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  lives_q, lives_d;
    logic        pulse_q, pulse_d;
    logic        crashed_q, crashed_d;
    logic        invuln_q, invuln_d;
    logic        over_q, over_d;
    logic [9:0]  speed_q, speed_d;

    // Widen every field to 12 bits so sums never wrap.
    logic [11:0] p_x_s, p_y_s, p_w_s, p_h_s;
    logic [11:0] a_x_s, a_y_s, a_w_s, a_h_s;
    logic        degenerate_s, hit_s;
    logic [15:0] crash_load_s;
    logic        unused_s;

    assign p_x_s = {1'b0, player_state[1]};
    assign p_y_s = {1'b0, player_state[2]};
    assign p_w_s = {1'b0, player_state[3]};
    assign p_h_s = {1'b0, player_state[4]};
    assign a_x_s = {1'b0, ai_state[1]};
    assign a_y_s = {1'b0, ai_state[2]};
    assign a_w_s = {1'b0, ai_state[3]};
    assign a_h_s = {1'b0, ai_state[4]};

    // A box no larger than both margins has no hitbox left; this also keeps
    // the "+ size - MARGIN" terms below from underflowing.
    assign degenerate_s = (p_w_s <= MIN_SIZE) || (p_h_s <= MIN_SIZE) ||
                          (a_w_s <= MIN_SIZE) || (a_h_s <= MIN_SIZE);

    assign hit_s = !degenerate_s &&
                   (p_x_s + MARGIN_W < a_x_s + a_w_s - MARGIN_W) &&
                   (a_x_s + MARGIN_W < p_x_s + p_w_s - MARGIN_W) &&
                   (p_y_s + MARGIN_W < a_y_s + a_h_s - MARGIN_W) &&
                   (a_y_s + MARGIN_W < p_y_s + p_h_s - MARGIN_W);

`ifdef COLLISION_SPEED_SCALED_CRASH_EN
    // player_speed/64 is its top four bits (bit 0 is the MSB).
    assign crash_load_s = 16'(CRASH_FRAMES) + {12'd0, player_speed[0:3]};
    assign unused_s     = ^{player_state[0], ai_state[0], player_speed[4:9]};
`else
    assign crash_load_s = 16'(CRASH_FRAMES);
    assign unused_s     = ^{player_state[0], ai_state[0], player_speed};
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= DRIVE;
            cnt_q     <= 16'd0;
            lives_q   <= 3'(NUM_LIVES);
            pulse_q   <= 1'b0;
            crashed_q <= 1'b0;
            invuln_q  <= 1'b0;
            over_q    <= 1'b0;
            speed_q   <= SPEED_MAX;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lives_q   <= lives_d;
            pulse_q   <= pulse_d;
            crashed_q <= crashed_d;
            invuln_q  <= invuln_d;
            over_q    <= over_d;
            speed_q   <= speed_d;
        end
    end

    // Next-state logic; advances only on frame_start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lives_d = lives_q;
        pulse_d = 1'b0;
        if (frame_start) begin
            case (state_q)
                DRIVE: begin
                    if (hit_s) begin
                        pulse_d = 1'b1;
                        lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                        if (lives_q <= 3'd1) begin
                            state_d = OVER;
                            cnt_d   = 16'd0;
                        end else begin
                            state_d = CRASH;
                            cnt_d   = crash_load_s;
                        end
                    end else begin
                        state_d = DRIVE;
                    end
                end
                CRASH: begin
                    if (cnt_q <= 16'd1) begin
                        state_d = GRACE;
                        cnt_d   = 16'(GRACE_FRAMES);
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                GRACE: begin
                    // The hit test is not consulted here, so a hit on the
                    // leaving frame is dropped.
                    if (cnt_q <= 16'd1) begin
                        state_d = DRIVE;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                OVER: begin
                    lives_d = 3'd0;
                end
                default: begin
                    state_d = DRIVE;
                    cnt_d   = 16'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode from the next state so flags register with the state.
    always_comb begin
        crashed_d = 1'b0;
        invuln_d  = 1'b0;
        over_d    = 1'b0;
        speed_d   = SPEED_MAX;
        case (state_d)
            DRIVE: speed_d = SPEED_MAX;
            CRASH: begin
                crashed_d = 1'b1;
                speed_d   = 10'd0;
            end
            GRACE: invuln_d = 1'b1;
            OVER: begin
                over_d  = 1'b1;
                speed_d = 10'd0;
            end
            default: speed_d = SPEED_MAX;
        endcase
    end

    assign collision_pulse = pulse_q;
    assign crashed         = crashed_q;
    assign invulnerable    = invuln_q;
    assign lives           = lives_q;
    assign game_over       = over_q;
    assign speed_limit     = speed_q;

endmodule

// File: tb/tb_car_collision_manager.sv
module tb_car_collision_manager;

    localparam int NL = 3;
    localparam int CF = 60;
    localparam int GF = 90;
    localparam int M  = 4;

    logic             clk = 1'b0;
    logic             resetN;
    logic             frame_start;
    logic [0:4][0:10] player_state;
    logic [0:4][0:10] ai_state;
    logic [0:9]       player_speed;
    logic             collision_pulse;
    logic             crashed;
    logic             invulnerable;
    logic [2:0]       lives;
    logic             game_over;
    logic [9:0]       speed_limit;

    car_collision_manager dut (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .player_state   (player_state),
        .ai_state       (ai_state),
        .player_speed   (player_speed),
        .collision_pulse(collision_pulse),
        .crashed        (crashed),
        .invulnerable   (invulnerable),
        .lives          (lives),
        .game_over      (game_over),
        .speed_limit    (speed_limit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scenario geometry and speed.
    int px, py, pw, ph, ax, ay, aw, ah, spd;

    // Reference model: frames left in each phase, lives, game-over flag.
    int m_lives, m_crash, m_grace;
    bit m_over;

    function automatic logic [0:4][0:10] pack(int id, int x, int y, int w, int h);
        return {11'(id), 11'(x), 11'(y), 11'(w), 11'(h)};
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Two shrunken boxes overlap when their intervals overlap on both axes.
    function automatic bit model_hit();
        if (pw <= 2 * M || ph <= 2 * M || aw <= 2 * M || ah <= 2 * M) return 1'b0;
        return (imax(px + M, ax + M) < imin(px + pw - M, ax + aw - M)) &&
               (imax(py + M, ay + M) < imin(py + ph - M, ay + ah - M));
    endfunction

    task automatic model_reset();
        m_lives = NL;
        m_crash = 0;
        m_grace = 0;
        m_over  = 1'b0;
    endtask

    task automatic model_step(input bit h, output bit p);
        p = 1'b0;
        if (m_over) begin
            m_lives = 0;
        end else if (m_crash > 0) begin
            m_crash--;
            if (m_crash == 0) m_grace = GF;
        end else if (m_grace > 0) begin
            m_grace--;
        end else if (h) begin
            p = 1'b1;
            m_lives--;
            if (m_lives == 0) m_over = 1'b1;
`ifdef COLLISION_SPEED_SCALED_CRASH_EN
            else m_crash = CF + spd / 64;
`else
            else m_crash = CF;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit ep);
        chk("pulse",       16'(collision_pulse), 16'(ep));
        chk("crashed",     16'(crashed),         16'(m_crash > 0));
        chk("invulnerable",16'(invulnerable),    16'(m_grace > 0));
        chk("lives",       16'(lives),           16'(m_lives));
        chk("game_over",   16'(game_over),       16'(m_over));
        chk("speed_limit", 16'(speed_limit),     (m_crash > 0 || m_over) ? 16'd0 : 16'd1023);
    endtask

    // One frame: pulse frame_start, check the result, then check one idle
    // clock to confirm the pulse is single-cycle and nothing else moves.
    task automatic frame();
        bit p;
        @(negedge clk);
        player_state = pack(0, px, py, pw, ph);
        ai_state     = pack(1, ax, ay, aw, ah);
        player_speed = 10'(spd);
        frame_start  = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        model_step(model_hit(), p);
        check_all(p);
        @(posedge clk);
        #1;
        check_all(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all(1'b0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN       = 1'b0;
        frame_start  = 1'b0;
        player_state = '0;
        ai_state     = '0;
        player_speed = '0;
        px = 256; py = 380; pw = 64; ph = 64;
        ax = 256; ay = 300; aw = 64; ah = 64;
        spd = 640;
        model_reset();
        do_reset();

        // Miss for five frames.
        repeat (5) frame();
        chk("miss_lives", 16'(lives), 16'd3);
        chk("miss_speed", 16'(speed_limit), 16'd1023);

        // First hit, then stay overlapping through crash and grace.
        ay = 340;
        frame();
        chk("hit_lives", 16'(lives), 16'd2);
        chk("hit_crashed", 16'(crashed), 16'd1);
        repeat (CF + GF) frame();
        chk("back_to_drive", 16'(invulnerable | crashed), 16'd0);
        frame();
        chk("second_hit_lives", 16'(lives), 16'd1);
        repeat (CF + GF) frame();
        frame();
        chk("third_hit_over", 16'(game_over), 16'd1);
        chk("third_hit_lives", 16'(lives), 16'd0);
        repeat (5) frame();

        // Edge cases along x.
        do_reset();
        ax = 320; repeat (2) frame();
        ax = 313; repeat (2) frame();
        chk("margin_band_lives", 16'(lives), 16'd3);
        ax = 311; frame();
        chk("x311_lives", 16'(lives), 16'd2);

        // Asynchronous reset in the middle of a crash.
        repeat (30) frame();
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all(1'b0);
        @(negedge clk);
        resetN = 1'b1;

        // Degenerate boxes never hit.
        ax = 256; aw = 8; repeat (3) frame();
        aw = 64; ah = 8; repeat (3) frame();
        pw = 8; ah = 64; repeat (3) frame();
        chk("degenerate_lives", 16'(lives), 16'd3);
        pw = 64;

        // Randomized positions, sizes and speed.
        for (int i = 0; i < 600; i++) begin
            ax  = 176 + $urandom_range(0, 160);
            ay  = 300 + $urandom_range(0, 160);
            aw  = $urandom_range(4, 80);
            ah  = $urandom_range(4, 80);
            spd = $urandom_range(0, 1023);
            if (m_over && $urandom_range(0, 3) == 0) do_reset();
            frame();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
